// File: rtl/note_recorder.sv
`default_nettype none
// ============================================================================
// Module   : note_recorder
// Purpose  : Watches four voice half-period buses during a live take and
//            encodes every held note into a 32-bit note word written to song
//            memory: [17:16]=channel, [15:8]=length, [7:0]=half-period.
// Ports    : clk, reset_n         clock, asynchronous active-low reset
//            arm, stop            take start (IDLE only) / take end (REC only)
//            ch_freq0..3 [7:0]    live half-period per channel, 0 = silent
//            mem_wr_en            one-cycle write strobe
//            mem_addr  [31:0]     BASE_ADDR + 4*index (0 when not writing)
//            mem_data  [31:0]     note word (0 when not writing)
//            recording            take in progress (including final writes)
//            full, dropped        sticky capacity / discard flags
//            note_count [15:0]    note words written this take
// Macro    : NOTE_RECORDER_TERMINATOR_EN adds a TERM state that writes
//            32'h8000_0000 after the last note; that slot is reserved.
// Revision : 1.0 - initial release
// ============================================================================
module note_recorder #(
  parameter int          MAX_NOTES = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        arm,
  input  logic        stop,
  input  logic [7:0]  ch_freq0,
  input  logic [7:0]  ch_freq1,
  input  logic [7:0]  ch_freq2,
  input  logic [7:0]  ch_freq3,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        recording,
  output logic        full,
  output logic        dropped,
  output logic [15:0] note_count
);

`ifdef NOTE_RECORDER_TERMINATOR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, FLUSH = 2'd2, TERM = 2'd3} state_t;
  localparam int LIMIT_INT = MAX_NOTES - 1;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, FLUSH = 2'd2} state_t;
  localparam int LIMIT_INT = MAX_NOTES;
`endif
  localparam logic [16:0] LIMIT = 17'(LIMIT_INT);

  state_t      state, state_next;
  logic [7:0]  freq      [4];
  logic [7:0]  pend_len  [4];
  logic [7:0]  pend_freq [4];
  logic [3:0]  pend_v;
  logic [3:0]  open_ch;
  logic [3:0]  drop_word;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [15:0] count;

  assign freq[0] = ch_freq0;
  assign freq[1] = ch_freq1;
  assign freq[2] = ch_freq2;
  assign freq[3] = ch_freq3;

  // Fixed-priority arbiter, ch0 highest.
  always_comb begin
    grant = 4'b0000;
    sel   = 2'd0;
    if (pend_v[0]) begin
      grant = 4'b0001; sel = 2'd0;
    end else if (pend_v[1]) begin
      grant = 4'b0010; sel = 2'd1;
    end else if (pend_v[2]) begin
      grant = 4'b0100; sel = 2'd2;
    end else if (pend_v[3]) begin
      grant = 4'b1000; sel = 2'd3;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [7:0] prev_q, len_q, prev_next, len_next;
    logic [7:0] plen_q, pfreq_q;
    logic       pv_q, emit, slot_free;

    // A slot being granted this edge can accept a new word on the same edge.
    assign slot_free = !pv_q || grant[i];

    always_comb begin
      prev_next = prev_q;
      len_next  = len_q;
      emit      = 1'b0;
      case (state)
        IDLE: begin
          // Notes already held when the take is armed open on the arm edge.
          if (arm) begin
            prev_next = freq[i];
            len_next  = (freq[i] != 8'd0) ? 8'd1 : 8'd0;
          end
        end
        REC: begin
          // The stop edge ends the take: channel state is frozen and FLUSH
          // closes whatever is open with its current length.
          if (!stop) begin
            if (prev_q == 8'd0) begin
              if (freq[i] != 8'd0) begin
                prev_next = freq[i];
                len_next  = 8'd1;
              end
            end else if (freq[i] == prev_q) begin
              if (len_q == 8'd255) begin
                emit     = 1'b1;
                len_next = 8'd1;
              end else begin
                len_next = len_q + 8'd1;
              end
            end else begin
              emit      = 1'b1;
              prev_next = freq[i];
              len_next  = (freq[i] != 8'd0) ? 8'd1 : 8'd0;
            end
          end
        end
        FLUSH: begin
          if (prev_q != 8'd0 && slot_free) begin
            emit      = 1'b1;
            prev_next = 8'd0;
            len_next  = 8'd0;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prev_q  <= 8'd0;
        len_q   <= 8'd0;
        pv_q    <= 1'b0;
        plen_q  <= 8'd0;
        pfreq_q <= 8'd0;
      end else begin
        prev_q <= prev_next;
        len_q  <= len_next;
        if (emit && slot_free) begin
          pv_q    <= 1'b1;
          plen_q  <= len_q;
          pfreq_q <= prev_q;
        end else if (grant[i]) begin
          pv_q <= 1'b0;
        end
      end
    end

    assign open_ch[i]   = (prev_q != 8'd0);
    assign drop_word[i] = emit && !slot_free;
    assign pend_v[i]    = pv_q;
    assign pend_len[i]  = plen_q;
    assign pend_freq[i] = pfreq_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (arm)  state_next = REC;
      REC:   if (stop) state_next = FLUSH;
      FLUSH: begin
        if (open_ch == 4'b0000 && pend_v == 4'b0000) begin
`ifdef NOTE_RECORDER_TERMINATOR_EN
          state_next = TERM;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef NOTE_RECORDER_TERMINATOR_EN
      TERM:  state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= 16'd0;
      full      <= 1'b0;
      dropped   <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= 32'd0;
      mem_data  <= 32'd0;
    end else begin
      state     <= state_next;
      mem_wr_en <= 1'b0;
      mem_addr  <= 32'd0;
      mem_data  <= 32'd0;
      if (state == IDLE && arm) begin
        count   <= 16'd0;
        full    <= 1'b0;
        dropped <= 1'b0;
      end else begin
        // Once full, granted slots are still drained, but their words are lost.
        if (pend_v != 4'b0000) begin
          if (!full) begin
            mem_wr_en <= 1'b1;
            mem_addr  <= BASE_ADDR + {14'd0, count, 2'b00};
            mem_data  <= {14'd0, sel, pend_len[sel], pend_freq[sel]};
            count     <= count + 16'd1;
            if (({1'b0, count} + 17'd1) == LIMIT)
              full <= 1'b1;
          end else begin
            dropped <= 1'b1;
          end
        end
        if (drop_word != 4'b0000)
          dropped <= 1'b1;
`ifdef NOTE_RECORDER_TERMINATOR_EN
        if (state == TERM) begin
          mem_wr_en <= 1'b1;
          mem_addr  <= BASE_ADDR + {14'd0, count, 2'b00};
          mem_data  <= 32'h8000_0000;
        end
`endif
      end
    end
  end

  // Held through the cycle of the final write so it falls just after it.
  assign recording  = (state != IDLE) || mem_wr_en;
  assign note_count = count;

endmodule
`default_nettype wire

// File: tb/tb_note_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_recorder
// Purpose  : Directed self-checking bench for note_recorder. A default
//            instance (MAX_NOTES=256) and a small one (MAX_NOTES=2) share the
//            stimulus; write traffic of each is logged for later comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_recorder;

`ifdef NOTE_RECORDER_TERMINATOR_EN
  localparam int   CAP_WRITES  = 1;
  localparam logic DROP_AFTER2 = 1'b1;
`else
  localparam int   CAP_WRITES  = 2;
  localparam logic DROP_AFTER2 = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, arm, stop;
  logic [7:0]  f0, f1, f2, f3;
  logic        wr1, rec1, full1, drop1;
  logic [31:0] addr1, data1;
  logic [15:0] cnt1;
  logic        wr2, rec2, full2, drop2;
  logic [31:0] addr2, data2;
  logic [15:0] cnt2;

  note_recorder #(.MAX_NOTES(256), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .stop(stop),
    .ch_freq0(f0), .ch_freq1(f1), .ch_freq2(f2), .ch_freq3(f3),
    .mem_wr_en(wr1), .mem_addr(addr1), .mem_data(data1),
    .recording(rec1), .full(full1), .dropped(drop1), .note_count(cnt1)
  );

  note_recorder #(.MAX_NOTES(2), .BASE_ADDR(32'h0)) dut_small (
    .clk(clk), .reset_n(reset_n), .arm(arm), .stop(stop),
    .ch_freq0(f0), .ch_freq1(f1), .ch_freq2(f2), .ch_freq3(f3),
    .mem_wr_en(wr2), .mem_addr(addr2), .mem_data(data2),
    .recording(rec2), .full(full2), .dropped(drop2), .note_count(cnt2)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  always @(negedge clk) begin
    if (wr1) q1.push_back({addr1, data1});
    if (wr2) q2.push_back({addr2, data2});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; arm = 1'b0; stop = 1'b0;
    f0 = 8'd0; f1 = 8'd0; f2 = 8'd0; f3 = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr",    {31'd0, wr1},   32'd0);
    chk("rst_addr",  addr1,          32'd0);
    chk("rst_data",  data1,          32'd0);
    chk("rst_rec",   {31'd0, rec1},  32'd0);
    chk("rst_flags", {30'd0, full1, drop1}, 32'd0);
    chk("rst_cnt",   {16'd0, cnt1},  32'd0);
    reset_n = 1'b1;
    tick();

    // Single note: 40 held for 10 edges (arm edge included), then silent.
    arm = 1'b1; f0 = 8'd40;
    tick();
    arm = 1'b0;
    chk("t1_rec_rise", {31'd0, rec1}, 32'd1);
    repeat (9) tick();
    f0 = 8'd0;
    tick();
    chk("t1_wr_lat", {31'd0, wr1}, 32'd0);
    tick();
    chk("t1_wr",   {31'd0, wr1}, 32'd1);
    chk("t1_addr", addr1, 32'h0);
    chk("t1_data", data1, 32'h0000_0A28);
    tick();
    chk("t1_cnt",  {16'd0, cnt1}, 32'd1);
    chk("t1_idle_addr", addr1, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("t1_rec_fall", {31'd0, rec1}, 32'd0);

    // Long note on ch1: two 255 splits then the 90-edge remainder.
    q1.delete();
    arm = 1'b1;
    tick();
    arm = 1'b0; f1 = 8'd50;
    repeat (600) tick();
    f1 = 8'd0;
    repeat (3) tick();
    chk("t2_nwr",  q1.size(), 32'd3);
    chk("t2_a0", (q1.size() > 0) ? q1[0][63:32] : 32'hFFFF_FFFF, 32'h0);
    chk("t2_d0", (q1.size() > 0) ? q1[0][31:0]  : 32'hFFFF_FFFF, 32'h0001_FF32);
    chk("t2_a1", (q1.size() > 1) ? q1[1][63:32] : 32'hFFFF_FFFF, 32'h4);
    chk("t2_d1", (q1.size() > 1) ? q1[1][31:0]  : 32'hFFFF_FFFF, 32'h0001_FF32);
    chk("t2_a2", (q1.size() > 2) ? q1[2][63:32] : 32'hFFFF_FFFF, 32'h8);
    chk("t2_d2", (q1.size() > 2) ? q1[2][31:0]  : 32'hFFFF_FFFF, 32'h0001_5A32);
    chk("t2_cnt", {16'd0, cnt1}, 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // ch0 and ch2 close on the same edge: ch0 first, ch2 the next cycle.
    arm = 1'b1;
    tick();
    arm = 1'b0; f0 = 8'd10; f2 = 8'd20;
    repeat (3) tick();
    f0 = 8'd0; f2 = 8'd0;
    tick();
    chk("t3_k_wr", {31'd0, wr1}, 32'd0);
    tick();
    chk("t3_k1_wr",   {31'd0, wr1}, 32'd1);
    chk("t3_k1_addr", addr1, 32'h0);
    chk("t3_k1_data", data1, 32'h0000_030A);
    tick();
    chk("t3_k2_wr",   {31'd0, wr1}, 32'd1);
    chk("t3_k2_addr", addr1, 32'h4);
    chk("t3_k2_data", data1, 32'h0002_0314);
    tick();
    chk("t3_k3_wr",  {31'd0, wr1}, 32'd0);
    chk("t3_cnt",    {16'd0, cnt1}, 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // ch3 held 20 edges, then stop: FLUSH force-closes it.
    arm = 1'b1;
    tick();
    arm = 1'b0; f3 = 8'd25;
    repeat (20) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("t4_f1_wr", {31'd0, wr1}, 32'd0);
    tick();
    chk("t4_wr",   {31'd0, wr1}, 32'd1);
    chk("t4_addr", addr1, 32'h0);
    chk("t4_data", data1, 32'h0003_1419);
    chk("t4_rec",  {31'd0, rec1}, 32'd1);
    tick();
`ifdef NOTE_RECORDER_TERMINATOR_EN
    chk("t4_term_gap", {31'd0, wr1}, 32'd0);
    tick();
    chk("t4_term_wr",   {31'd0, wr1}, 32'd1);
    chk("t4_term_addr", addr1, 32'h4);
    chk("t4_term_data", data1, 32'h8000_0000);
    chk("t4_term_rec",  {31'd0, rec1}, 32'd1);
    tick();
`endif
    chk("t4_rec_fall", {31'd0, rec1}, 32'd0);
    chk("t4_cnt", {16'd0, cnt1}, 32'd1);
    f3 = 8'd0;
    tick();

    // Capacity: MAX_NOTES=2 instance receives three notes.
    q1.delete();
    q2.delete();
    arm = 1'b1;
    tick();
    arm = 1'b0; f0 = 8'd5;
    repeat (2) tick();
    f0 = 8'd0;
    tick();
    f1 = 8'd6;
    tick();
    f1 = 8'd0;
    repeat (3) tick();
    chk("t5_full2",   {31'd0, full2}, 32'd1);
    chk("t5_drop2a",  {31'd0, drop2}, {31'd0, DROP_AFTER2});
    chk("t5_full1",   {31'd0, full1}, 32'd0);
    f2 = 8'd7;
    tick();
    f2 = 8'd0;
    repeat (4) tick();
    chk("t5_drop2b",  {31'd0, drop2}, 32'd1);
    chk("t5_nwr2",    q2.size(), CAP_WRITES);
    chk("t5_cnt2",    {16'd0, cnt2}, CAP_WRITES);
    chk("t5_a0", (q2.size() > 0) ? q2[0][63:32] : 32'hFFFF_FFFF, 32'h0);
    chk("t5_d0", (q2.size() > 0) ? q2[0][31:0]  : 32'hFFFF_FFFF, 32'h0000_0205);
`ifndef NOTE_RECORDER_TERMINATOR_EN
    chk("t5_a1", (q2.size() > 1) ? q2[1][63:32] : 32'hFFFF_FFFF, 32'h4);
    chk("t5_d1", (q2.size() > 1) ? q2[1][31:0]  : 32'hFFFF_FFFF, 32'h0001_0106);
`endif
    chk("t5_nwr1",  q1.size(), 32'd3);
    chk("t5_cnt1",  {16'd0, cnt1}, 32'd3);
    chk("t5_drop1", {31'd0, drop1}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (5) tick();

    // Reset in the middle of a take with a write still pending.
    arm = 1'b1;
    tick();
    arm = 1'b0; f0 = 8'd9; f1 = 8'd9;
    repeat (2) tick();
    f0 = 8'd0; f1 = 8'd0;
    repeat (2) tick();
    chk("t6_pre_wr", {31'd0, wr1}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wr",   {31'd0, wr1}, 32'd0);
    chk("t6_rst_addr", addr1, 32'd0);
    chk("t6_rst_data", data1, 32'd0);
    chk("t6_rst_rec",  {31'd0, rec1}, 32'd0);
    chk("t6_rst_cnt",  {16'd0, cnt1}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    arm = 1'b1; f0 = 8'd3;
    tick();
    arm = 1'b0; f0 = 8'd0;
    tick();
    tick();
    chk("t6_re_wr",   {31'd0, wr1}, 32'd1);
    chk("t6_re_addr", addr1, 32'h0);
    chk("t6_re_data", data1, 32'h0000_0103);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
